// File: rtl/tea_pkg.sv
// Shared constants and the TEA round function for the streaming cipher block.
// One core pipeline stage is one full TEA cycle, which is two Feistel rounds.
package tea_pkg;

    localparam logic [31:0] DELTA        = 32'h9E3779B9;
    localparam int          CORE_LATENCY = 32;
    localparam int          BLOCK_W      = 64;
    localparam int          KEY_W        = 128;

    // One TEA cycle; key is {k3,k2,k1,k0}, sum is the cycle's running sum.
    function automatic logic [BLOCK_W-1:0] tea_cycle(
        input logic [31:0]      v0,
        input logic [31:0]      v1,
        input logic [KEY_W-1:0] key,
        input logic [31:0]      sum
    );
        logic [31:0] y;
        logic [31:0] z;
        y = v0 + (((v1 << 4) + key[31:0]) ^ (v1 + sum)
                  ^ ((v1 >> 5) + key[63:32]));
        z = v1 + (((y << 4) + key[95:64]) ^ (y + sum)
                  ^ ((y >> 5) + key[127:96]));
        return {y, z};
    endfunction

endpackage

// File: rtl/tea_core.sv
// Free-running 32-stage TEA encryption pipeline.
// Stage 0 registers the inputs; stage s holds the result after s cycles.
module tea_core
    import tea_pkg::*;
(
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] v0,
    input  logic [31:0] v1,
    input  logic [31:0] k0,
    input  logic [31:0] k1,
    input  logic [31:0] k2,
    input  logic [31:0] k3,
    output logic [31:0] out_v0,
    output logic [31:0] out_v1
);

    logic [31:0]      v0_q  [0:CORE_LATENCY];
    logic [31:0]      v0_d  [0:CORE_LATENCY];
    logic [31:0]      v1_q  [0:CORE_LATENCY];
    logic [31:0]      v1_d  [0:CORE_LATENCY];
    logic [KEY_W-1:0] key_q [0:CORE_LATENCY-1];
    logic [KEY_W-1:0] key_d [0:CORE_LATENCY-1];

    // Each stage applies one TEA cycle with its constant sum s*DELTA.
    always_comb begin
        v0_d[0]  = v0;
        v1_d[0]  = v1;
        key_d[0] = {k3, k2, k1, k0};
        for (int s = 1; s <= CORE_LATENCY; s++) begin
            {v0_d[s], v1_d[s]} = tea_cycle(v0_q[s-1], v1_q[s-1],
                                           key_q[s-1], DELTA * 32'(s));
        end
        for (int s = 1; s < CORE_LATENCY; s++) begin
            key_d[s] = key_q[s-1];
        end
    end

    // Pipeline registers, cleared so no stale block survives reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int s = 0; s <= CORE_LATENCY; s++) begin
                v0_q[s] <= '0;
                v1_q[s] <= '0;
            end
            for (int s = 0; s < CORE_LATENCY; s++) begin
                key_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s <= CORE_LATENCY; s++) begin
                v0_q[s] <= v0_d[s];
                v1_q[s] <= v1_d[s];
            end
            for (int s = 0; s < CORE_LATENCY; s++) begin
                key_q[s] <= key_d[s];
            end
        end
    end

    assign out_v0 = v0_q[CORE_LATENCY];
    assign out_v1 = v1_q[CORE_LATENCY];

endmodule

// File: rtl/tea_out_fifo.sv
// Synchronous ciphertext FIFO with occupancy count.
// Head data reads as zero while empty so outputs are clean after reset.
module tea_out_fifo
    import tea_pkg::*;
#(
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               push,
    input  logic [BLOCK_W-1:0] push_data,
    input  logic               pop,
    output logic [BLOCK_W-1:0] pop_data,
    output logic [CW-1:0]      count,
    output logic               empty,
    output logic               full
);

    logic [BLOCK_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // Pointer and count state.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset as count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    // Overflow and underflow guards.
    always_ff @(posedge clk) begin
        if (nrst) begin
            assert (!(push && full))
                else $error("tea_out_fifo: push while full");
            assert (!(pop && empty))
                else $error("tea_out_fifo: pop while empty");
        end
    end

endmodule

// File: rtl/tea_stream_ctrl.sv
// Streaming TEA wrapper: credit-based issue into a non-stalling core,
// with results captured in order into an output FIFO.
module tea_stream_ctrl
    import tea_pkg::*;
#(
    parameter int FIFO_DEPTH   = 64,
    parameter int CORE_LATENCY = tea_pkg::CORE_LATENCY
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_v0,
    input  logic [31:0]      in_v1,
    input  logic [KEY_W-1:0] in_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_v0,
    output logic [31:0]      out_v1,
    output logic             busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [CW-1:0]         fifo_count;
    logic [CW:0]           credit_used;
    logic [31:0]           core_v0, core_v1;
    logic [31:0]           cin_v0, cin_v1;
    logic [KEY_W-1:0]      cin_key;
    logic [CW-1:0]         in_flight_q, in_flight_d;
    logic [CORE_LATENCY:0] tag_q, tag_d;

    assign credit_used = {1'b0, in_flight_q} + {1'b0, fifo_count};
    assign in_ready    = (credit_used < (CW+1)'(FIFO_DEPTH));
    assign accept      = in_valid && in_ready;
    assign push        = tag_q[CORE_LATENCY];
    assign out_valid   = !fifo_empty;
    assign pop         = out_valid && out_ready;
    assign busy        = (in_flight_q != '0) || !fifo_empty;

    // Core sees the block only in its accept cycle, zeros otherwise.
    always_comb begin
        cin_v0  = accept ? in_v0  : '0;
        cin_v1  = accept ? in_v1  : '0;
        cin_key = accept ? in_key : '0;
    end

    // Tag line tracks accepted blocks alongside the core pipeline.
    always_comb begin
        tag_d       = {tag_q[CORE_LATENCY-1:0], accept};
        in_flight_d = in_flight_q + CW'(accept) - CW'(push);
    end

    // Tag and in-flight credit state.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            tag_q       <= '0;
            in_flight_q <= '0;
        end else begin
            tag_q       <= tag_d;
            in_flight_q <= in_flight_d;
        end
    end

    tea_core u_core (
        .clk    (clk),
        .nrst   (nrst),
        .v0     (cin_v0),
        .v1     (cin_v1),
        .k0     (cin_key[31:0]),
        .k1     (cin_key[63:32]),
        .k2     (cin_key[95:64]),
        .k3     (cin_key[127:96]),
        .out_v0 (core_v0),
        .out_v1 (core_v1)
    );

    tea_out_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .nrst      (nrst),
        .push      (push),
        .push_data ({core_v0, core_v1}),
        .pop       (pop),
        .pop_data  ({out_v0, out_v1}),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Credit accounting must never exceed the buffer size.
    always_ff @(posedge clk) begin
        if (nrst) begin
            assert (credit_used <= (CW+1)'(FIFO_DEPTH))
                else $error("tea_stream_ctrl: credit overrun");
            assert (!(push && fifo_full))
                else $error("tea_stream_ctrl: push into full fifo");
        end
    end

endmodule

// File: tb/tb_tea_stream_ctrl.sv
// Directed bench for tea_stream_ctrl with a reference TEA model.
// A depth-4 second instance exercises credit backpressure.
module tb_tea_stream_ctrl;

    logic         clk = 1'b0;
    logic         nrst;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0]  in_v0, in_v1, out_v0, out_v1;
    logic [127:0] in_key;
    logic         b_valid, b_in_ready, b_out_valid, b_ready, b_busy;
    logic [31:0]  b_v0, b_v1;

    int checks   = 0;
    int failures = 0;
    int acc_cnt  = 0;
    int pop_cnt  = 0;
    logic [63:0] expq[$];

    always #5 clk = ~clk;

    tea_stream_ctrl u_dut (
        .clk(clk), .nrst(nrst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_v0(in_v0), .in_v1(in_v1), .in_key(in_key),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_v0(out_v0), .out_v1(out_v1), .busy(busy)
    );

    tea_stream_ctrl #(.FIFO_DEPTH(4)) u_bp (
        .clk(clk), .nrst(nrst),
        .in_valid(b_valid), .in_ready(b_in_ready),
        .in_v0(in_v0), .in_v1(in_v1), .in_key(in_key),
        .out_valid(b_out_valid), .out_ready(b_ready),
        .out_v0(b_v0), .out_v1(b_v1), .busy(b_busy)
    );

    function automatic logic [63:0] tea_ref(
        input logic [31:0] a, input logic [31:0] b,
        input logic [127:0] k
    );
        logic [31:0] sum = 32'd0;
        for (int i = 0; i < 32; i++) begin
            sum = sum + 32'h9E3779B9;
            a = a + (((b << 4) + k[31:0]) ^ (b + sum)
                     ^ ((b >> 5) + k[63:32]));
            b = b + (((a << 4) + k[95:64]) ^ (a + sum)
                     ^ ((a >> 5) + k[127:96]));
        end
        return {a, b};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: sampled mid-cycle, ahead of the edge that transfers.
    always @(negedge clk) begin
        if (nrst) begin
            if (out_valid && out_ready) begin
                pop_cnt++;
                chk("pop_has_expected", 64'(expq.size() != 0), 64'd1);
                if (expq.size() != 0)
                    chk("pop_data", {out_v0, out_v1}, expq.pop_front());
            end
            if (in_valid && in_ready) begin
                acc_cnt++;
                expq.push_back(tea_ref(in_v0, in_v1, in_key));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(string tag);
        int n = 0;
        while ((busy || expq.size() != 0) && n < 300) begin
            step();
            n++;
        end
        chk(tag, 64'(n < 300), 64'd1);
    endtask

    logic [63:0] bexp [10];
    logic [63:0] head;
    int          nb, a0, p0, seen;
    logic        acc, drop;

    initial begin
        nrst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        b_valid = 1'b0; b_ready = 1'b0;
        in_v0 = '0; in_v1 = '0; in_key = '0;
        repeat (3) step();
        nrst = 1'b1;
        step();

        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_data", {out_v0, out_v1}, 64'd0);
        chk("rst_bp_ready", 64'(b_in_ready), 64'd1);

        // Single zero block: known-answer vector and exact latency.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        chk("single_busy", 64'(busy), 64'd1);
        for (int n = 1; n <= 33; n++) begin
            step();
            if (n == 32) chk("single_lat_early", 64'(out_valid), 64'd0);
        end
        chk("single_lat_k33", 64'(out_valid), 64'd1);
        chk("single_kat", {out_v0, out_v1}, 64'h41EA3A0A_94BAA940);
        drain("single_drain");

        // 100 back-to-back random blocks.
        a0 = acc_cnt; p0 = pop_cnt; drop = 1'b0;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_v0 = $urandom; in_v1 = $urandom;
            in_key = {$urandom, $urandom, $urandom, $urandom};
            if (!in_ready) drop = 1'b1;
            step();
        end
        in_valid = 1'b0;
        chk("stream_ready_held", 64'(drop), 64'd0);
        chk("stream_accepts", 64'(acc_cnt - a0), 64'd100);
        drain("stream_drain");
        chk("stream_pops", 64'(pop_cnt - p0), 64'd100);

        // Depth-4 instance: credit limit with downstream stalled.
        nb = 0;
        for (int c = 0; c < 10; c++) begin
            b_valid = 1'b1;
            in_v0 = 32'h1000 + 32'(c); in_v1 = 32'hABCD0000 ^ 32'(c);
            in_key = {4{32'h01234567 + 32'(c)}};
            acc = b_in_ready;
            if (acc) bexp[nb] = tea_ref(in_v0, in_v1, in_key);
            step();
            if (acc) nb++;
        end
        b_valid = 1'b0;
        chk("bp_accepts", 64'(nb), 64'd4);
        chk("bp_ready_low", 64'(b_in_ready), 64'd0);
        repeat (40) step();
        chk("bp_out_valid", 64'(b_out_valid), 64'd1);
        head = {b_v0, b_v1};
        repeat (3) step();
        chk("bp_head_hold", {b_v0, b_v1}, head);
        chk("bp_ready_still_low", 64'(b_in_ready), 64'd0);
        b_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("bp_pop_valid", 64'(b_out_valid), 64'd1);
            chk("bp_pop_data", {b_v0, b_v1}, bexp[j]);
            step();
        end
        chk("bp_empty", 64'(b_out_valid), 64'd0);
        chk("bp_ready_back", 64'(b_in_ready), 64'd1);
        chk("bp_idle", 64'(b_busy), 64'd0);

        // Concurrent push/pop with random downstream stalls.
        a0 = acc_cnt; p0 = pop_cnt;
        for (int i = 0; i < 200; i++) begin
            in_valid  = 1'b1;
            out_ready = 1'($urandom_range(0, 1));
            in_v0 = $urandom; in_v1 = $urandom;
            in_key = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("rand_drain");
        chk("rand_no_loss", 64'(pop_cnt - p0), 64'(acc_cnt - a0));

        // Reset one edge mid-stream discards everything.
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_v0 = 32'(i); in_v1 = ~32'(i); in_key = {4{32'(i)}};
            step();
        end
        in_valid = 1'b0;
        repeat (5) step();
        nrst = 1'b0;
        expq.delete();
        step();
        nrst = 1'b1;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 45; i++) begin
            if (out_valid) seen++;
            step();
        end
        chk("mrst_no_stale", 64'(seen), 64'd0);

        // Alternating all-zero and all-one keys on consecutive blocks.
        a0 = acc_cnt; p0 = pop_cnt;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_v0 = $urandom; in_v1 = $urandom;
            in_key = (i % 2 == 1) ? {128{1'b1}} : 128'd0;
            step();
        end
        in_valid = 1'b0;
        drain("keys_drain");
        chk("keys_pops", 64'(pop_cnt - p0), 64'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
